// File: rtl/ysyx_23060096_imem_resp_pkg.sv
// Shared types and constants for the instruction-memory responder.
package ysyx_23060096_pkg;

  // Responder FSM: accept a request, count down the access latency, present the response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_state_t;

  // Byte address of word 0 of the instruction array.
  localparam logic [31:0] IMEM_BASE_ADDR = 32'h8000_0000;

  // RISC-V encodings that make convenient preload images.
  localparam logic [31:0] INST_NOP    = 32'h0000_0013;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  // Width of the latency down-counter; at least one bit even when LATENCY is 1.
  function automatic int cnt_width(input int latency);
    return (latency > 1) ? $clog2(latency) : 1;
  endfunction

endpackage

// File: rtl/ysyx_23060096_imem_resp_if.sv
// Fetch request/response handshake plus the preload write port.
interface ysyx_23060096_imem_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_inst;
  logic              resp_err;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_data;

  // The core / simulation environment side.
  modport master (
    output req_valid, req_addr, resp_ready, ld_en, ld_addr, ld_data,
    input  req_ready, resp_valid, resp_inst, resp_err
  );

  // The instruction-memory responder side.
  modport slave (
    input  req_valid, req_addr, resp_ready, ld_en, ld_addr, ld_data,
    output req_ready, resp_valid, resp_inst, resp_err
  );
endinterface

// File: rtl/ysyx_23060096_imem_resp_array.sv
// Word storage: one synchronous write port, one registered read port.
// No reset so the array maps onto block RAM; a read and a write to the
// same word on one edge return the old contents.
module ysyx_23060096_imem_array #(
  parameter int DEPTH_WORDS = 4096,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [31:0]      wr_data_i,
  input  logic             rd_en_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [31:0]      rd_data_o
);
  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rd_data_q;

  // Preload writes land in the array.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_idx_i] <= wr_data_i;
  end

  // Registered read; holds its value whenever the read enable is low.
  always_ff @(posedge clk) begin
    if (rd_en_i) rd_data_q <= mem_q[rd_idx_i];
  end

  assign rd_data_o = rd_data_q;
endmodule

// File: rtl/ysyx_23060096_imem_resp.sv
// Instruction-memory responder: valid/ready fetch requests answered after a
// fixed LATENCY, with access-fault reporting for misaligned or out-of-range pcs.
module ysyx_23060096_imem_resp
  import ysyx_23060096_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH_WORDS = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(IMEM_BASE_ADDR),
  parameter int                LATENCY     = 1
) (
  input logic                  clk,
  input logic                  rstn,
  ysyx_23060096_imem_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = cnt_width(LATENCY);

  // Bounds are one bit wider than the address so BASE_ADDR + size cannot wrap.
  localparam logic [ADDR_W:0] LO_BOUND = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] HI_BOUND = LO_BOUND + (ADDR_W+1)'(4 * DEPTH_WORDS);

  function automatic logic addr_fault(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] wide;
    wide = {1'b0, a};
    return (a[1:0] != 2'b00) || (wide < LO_BOUND) || (wide >= HI_BOUND);
  endfunction

  // Only meaningful once addr_fault() has cleared the address.
  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  imem_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic              rd_en;
  logic              wr_en;
  logic [31:0]       rd_data;

  // Next-state logic: accept in IDLE, count down in WAIT, hold in RESP until taken.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          err_d   = addr_fault(addr_q);
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; an asynchronous reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  // The array is read on the capture edge only, and never for a faulting address.
  assign rd_en = (state_q == WAIT) && (cnt_q == '0) && !addr_fault(addr_q);
  assign wr_en = bus.ld_en && !addr_fault(bus.ld_addr);

  ysyx_23060096_imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_idx_i  (word_idx(bus.ld_addr)),
    .wr_data_i (bus.ld_data),
    .rd_en_i   (rd_en),
    .rd_idx_i  (word_idx(addr_q)),
    .rd_data_o (rd_data)
  );

  // The array output register is not reset, so the instruction is qualified
  // by registered state; it reads as zero outside RESP and on a fault.
  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_err   = err_q;
  assign bus.resp_inst  = ((state_q == RESP) && !err_q) ? rd_data : 32'h0;
endmodule

// File: tb/tb_ysyx_23060096_imem_resp.sv
// Bench for the instruction-memory responder: three instances at LATENCY 1, 3 and 4.
module tb_ysyx_23060096_imem_resp;
  import ysyx_23060096_pkg::*;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  logic             clk = 1'b0;
  logic [2:0]       rstn_s = 3'b000;
  logic [2:0]       req_valid_s = '0;
  logic [2:0][31:0] req_addr_s = '0;
  logic [2:0]       resp_ready_s = 3'b111;
  logic [2:0]       ld_en_s = '0;
  logic [2:0][31:0] ld_addr_s = '0;
  logic [2:0][31:0] ld_data_s = '0;
  logic [2:0]       req_ready_s;
  logic [2:0]       resp_valid_s;
  logic [2:0]       resp_err_s;
  logic [2:0][31:0] resp_inst_s;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t sb_q[$];

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 3 : 4;
  endfunction

  function automatic logic exp_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < 32'h8000_0000) || (a >= 32'h8000_4000);
  endfunction

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    ysyx_23060096_imem_if #(.ADDR_W(32)) bus ();
    assign bus.req_valid     = req_valid_s[gi];
    assign bus.req_addr      = req_addr_s[gi];
    assign bus.resp_ready    = resp_ready_s[gi];
    assign bus.ld_en         = ld_en_s[gi];
    assign bus.ld_addr       = ld_addr_s[gi];
    assign bus.ld_data       = ld_data_s[gi];
    assign req_ready_s[gi]   = bus.req_ready;
    assign resp_valid_s[gi]  = bus.resp_valid;
    assign resp_err_s[gi]    = bus.resp_err;
    assign resp_inst_s[gi]   = bus.resp_inst;

    ysyx_23060096_imem_resp #(
      .ADDR_W      (32),
      .DEPTH_WORDS (4096),
      .BASE_ADDR   (32'h8000_0000),
      .LATENCY     (lat_of(gi))
    ) u_dut (
      .clk  (clk),
      .rstn (rstn_s[gi]),
      .bus  (bus)
    );
  end

  // Called at a negedge; returns at the next negedge.
  task automatic preload(input int d, input logic [31:0] a, input logic [31:0] v);
    ld_en_s[d] = 1'b1; ld_addr_s[d] = a; ld_data_s[d] = v;
    @(negedge clk);
    ld_en_s[d] = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the accept edge.
  task automatic issue_req(input int d, input logic [31:0] a, input logic [31:0] v,
                           input bit push, output int acc_cyc);
    exp_t e;
    req_valid_s[d] = 1'b1; req_addr_s[d] = a;
    if (push) begin
      e.err  = exp_fault(a);
      e.inst = e.err ? 32'h0 : v;
      sb_q.push_back(e);
    end
    @(posedge clk);
    acc_cyc = cyc;
    @(negedge clk);
    req_valid_s[d] = 1'b0;
  endtask

  // Counts edges after the accept edge until resp_valid; optionally drives a
  // preload write onto the response-capture edge. n is 40 on timeout.
  task automatic wait_resp(input int d, input bit coll, input logic [31:0] la,
                           input logic [31:0] lv, output int n);
    n = 0;
    while (!resp_valid_s[d] && n < 40) begin
      if (coll && n == lat_of(d) - 1) begin
        ld_en_s[d] = 1'b1; ld_addr_s[d] = la; ld_data_s[d] = lv;
      end
      @(negedge clk);
      ld_en_s[d] = 1'b0;
      n++;
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      total++; if (req_ready_s[d] !== 1'b1) begin $display("FAIL reset_req_ready d=%0d got=%b want=1", d, req_ready_s[d]); bad++; end
      total++; if (resp_valid_s[d] !== 1'b0) begin $display("FAIL reset_resp_valid d=%0d got=%b want=0", d, resp_valid_s[d]); bad++; end
      total++; if (resp_inst_s[d] !== 32'h0) begin $display("FAIL reset_resp_inst d=%0d got=%h want=0", d, resp_inst_s[d]); bad++; end
      total++; if (resp_err_s[d] !== 1'b0) begin $display("FAIL reset_resp_err d=%0d got=%b want=0", d, resp_err_s[d]); bad++; end
      $display("reset d=%0d req_ready=%b resp_valid=%b", d, req_ready_s[d], resp_valid_s[d]);
    end
  endtask

  task automatic test_basic();
    int n, acc;
    exp_t e;
    preload(0, 32'h8000_0000, INST_EBREAK);
    preload(0, 32'h8000_0001, 32'hBAD0_BAD0);   // misaligned: must be dropped
    preload(0, 32'h8000_4000, 32'hBAD1_BAD1);   // out of range: must be dropped
    issue_req(0, 32'h8000_0000, INST_EBREAK, 1'b1, acc);
    wait_resp(0, 1'b0, 32'h0, 32'h0, n);
    e = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
    total++; if (n !== 1) begin $display("FAIL basic_latency got=%0d want=1", n); bad++; end
    total++; if (resp_inst_s[0] !== e.inst) begin $display("FAIL basic_inst got=%h want=%h", resp_inst_s[0], e.inst); bad++; end
    total++; if (resp_err_s[0] !== e.err) begin $display("FAIL basic_err got=%b want=%b", resp_err_s[0], e.err); bad++; end
    total++; if (req_ready_s[0] !== 1'b0) begin $display("FAIL basic_busy got=%b want=0", req_ready_s[0]); bad++; end
    @(negedge clk);
    total++; if (req_ready_s[0] !== 1'b1) begin $display("FAIL basic_ready_back got=%b want=1", req_ready_s[0]); bad++; end
    total++; if (resp_valid_s[0] !== 1'b0) begin $display("FAIL basic_valid_drop got=%b want=0", resp_valid_s[0]); bad++; end
    $display("basic addr=80000000 lat=%0d inst=%h err=%b", n, e.inst, e.err);
  endtask

  task automatic test_latency();
    int n, acc;
    exp_t e;
    preload(1, 32'h8000_0004, INST_NOP);
    issue_req(1, 32'h8000_0004, INST_NOP, 1'b1, acc);
    wait_resp(1, 1'b0, 32'h0, 32'h0, n);
    e = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
    total++; if (n !== 3) begin $display("FAIL lat3_latency got=%0d want=3", n); bad++; end
    total++; if (resp_inst_s[1] !== e.inst) begin $display("FAIL lat3_inst got=%h want=%h", resp_inst_s[1], e.inst); bad++; end
    @(negedge clk);
    $display("latency3 addr=80000004 lat=%0d inst=%h", n, e.inst);
  endtask

  task automatic test_backpressure();
    int n, acc, err_seen;
    exp_t e;
    preload(1, 32'h8000_0100, 32'hA5A5_5A5A);
    resp_ready_s[1] = 1'b0;
    issue_req(1, 32'h8000_0100, 32'hA5A5_5A5A, 1'b1, acc);
    wait_resp(1, 1'b0, 32'h0, 32'h0, n);
    e = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
    total++; if (n !== 3) begin $display("FAIL bp_latency got=%0d want=3", n); bad++; end
    err_seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (resp_valid_s[1] !== 1'b1 || resp_inst_s[1] !== e.inst || resp_err_s[1] !== e.err || req_ready_s[1] !== 1'b0) begin
        $display("FAIL bp_hold cycle=%0d got valid=%b inst=%h err=%b ready=%b want valid=1 inst=%h err=%b ready=0",
                 i, resp_valid_s[1], resp_inst_s[1], resp_err_s[1], req_ready_s[1], e.inst, e.err);
        err_seen++;
      end
      @(negedge clk);
    end
    total++; if (err_seen != 0) bad++;
    resp_ready_s[1] = 1'b1;
    @(negedge clk);
    total++; if (req_ready_s[1] !== 1'b1) begin $display("FAIL bp_release_ready got=%b want=1", req_ready_s[1]); bad++; end
    total++; if (resp_valid_s[1] !== 1'b0) begin $display("FAIL bp_release_valid got=%b want=0", resp_valid_s[1]); bad++; end
    $display("backpressure addr=80000100 inst=%h held=5", e.inst);
  endtask

  task automatic test_faults();
    logic [31:0] addrs [5];
    int n, acc;
    exp_t e;
    addrs = '{32'h8000_0002, 32'h8000_4000, 32'h7FFF_FFFC, 32'hFFFF_FFFC, 32'h8000_3FFC};
    preload(0, 32'h8000_3FFC, 32'h1234_5678);   // last word, also what a wrapped index would hit
    for (int i = 0; i < 5; i++) begin
      issue_req(0, addrs[i], 32'h1234_5678, 1'b1, acc);
      wait_resp(0, 1'b0, 32'h0, 32'h0, n);
      e = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
      total++; if (n !== 1) begin $display("FAIL fault_latency addr=%h got=%0d want=1", addrs[i], n); bad++; end
      total++; if (resp_err_s[0] !== e.err) begin $display("FAIL fault_err addr=%h got=%b want=%b", addrs[i], resp_err_s[0], e.err); bad++; end
      total++; if (resp_inst_s[0] !== e.inst) begin $display("FAIL fault_inst addr=%h got=%h want=%h", addrs[i], resp_inst_s[0], e.inst); bad++; end
      $display("fault addr=%h err=%b inst=%h", addrs[i], resp_err_s[0], resp_inst_s[0]);
      @(negedge clk);
    end
  endtask

  task automatic test_load_collision();
    int n, acc;
    exp_t e;
    preload(0, 32'h8000_0008, 32'h1111_1111);
    issue_req(0, 32'h8000_0008, 32'h1111_1111, 1'b1, acc);
    wait_resp(0, 1'b1, 32'h8000_0008, 32'hDEAD_BEEF, n);
    e = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
    total++; if (resp_inst_s[0] !== e.inst) begin $display("FAIL coll_old got=%h want=%h", resp_inst_s[0], e.inst); bad++; end
    @(negedge clk);
    issue_req(0, 32'h8000_0008, 32'hDEAD_BEEF, 1'b1, acc);
    wait_resp(0, 1'b0, 32'h0, 32'h0, n);
    e = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
    total++; if (resp_inst_s[0] !== e.inst) begin $display("FAIL coll_new got=%h want=%h", resp_inst_s[0], e.inst); bad++; end
    @(negedge clk);
    $display("collision addr=80000008 second_read=%h", e.inst);
  endtask

  task automatic test_back_to_back();
    int n, acc, prev_acc;
    exp_t e;
    for (int i = 0; i < 4; i++) preload(1, 32'h8000_0200 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
    prev_acc = 0;
    for (int i = 0; i < 4; i++) begin
      issue_req(1, 32'h8000_0200 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 1'b1, acc);
      wait_resp(1, 1'b0, 32'h0, 32'h0, n);
      e = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
      total++; if (resp_inst_s[1] !== e.inst) begin $display("FAIL b2b_inst i=%0d got=%h want=%h", i, resp_inst_s[1], e.inst); bad++; end
      if (i > 0) begin
        total++; if (acc - prev_acc !== 5) begin $display("FAIL b2b_spacing i=%0d got=%0d want=5", i, acc - prev_acc); bad++; end
      end
      $display("b2b i=%0d inst=%h spacing=%0d", i, resp_inst_s[1], acc - prev_acc);
      prev_acc = acc;
      @(negedge clk);   // handshake edge; responder idle again
    end
  endtask

  task automatic test_reset_mid_wait();
    int n, acc, seen;
    exp_t e;
    preload(2, 32'h8000_0010, 32'hCAFE_F00D);
    issue_req(2, 32'h8000_0010, 32'hCAFE_F00D, 1'b0, acc);
    @(posedge clk);
    total++; if (req_ready_s[2] !== 1'b0) begin $display("FAIL rst_busy got=%b want=0", req_ready_s[2]); bad++; end
    #1 rstn_s[2] = 1'b0;
    #1;
    total++; if (resp_valid_s[2] !== 1'b0) begin $display("FAIL rst_valid got=%b want=0", resp_valid_s[2]); bad++; end
    total++; if (resp_inst_s[2] !== 32'h0) begin $display("FAIL rst_inst got=%h want=0", resp_inst_s[2]); bad++; end
    total++; if (resp_err_s[2] !== 1'b0) begin $display("FAIL rst_err got=%b want=0", resp_err_s[2]); bad++; end
    total++; if (req_ready_s[2] !== 1'b1) begin $display("FAIL rst_ready got=%b want=1", req_ready_s[2]); bad++; end
    @(negedge clk);
    @(negedge clk);
    rstn_s[2] = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_valid_s[2] === 1'b1) seen++;
    end
    total++; if (seen !== 0) begin $display("FAIL rst_no_resp got=%0d want=0", seen); bad++; end
    issue_req(2, 32'h8000_0010, 32'hCAFE_F00D, 1'b1, acc);
    wait_resp(2, 1'b0, 32'h0, 32'h0, n);
    e = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
    total++; if (n !== 4) begin $display("FAIL rst_relat got=%0d want=4", n); bad++; end
    total++; if (resp_inst_s[2] !== e.inst) begin $display("FAIL rst_retained got=%h want=%h", resp_inst_s[2], e.inst); bad++; end
    @(negedge clk);
    $display("reset_mid_wait aborted_resps=%0d reread=%h", seen, e.inst);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rstn_s = 3'b111;
    @(negedge clk);
    test_reset();
    test_basic();
    test_latency();
    test_backpressure();
    test_faults();
    test_load_collision();
    test_back_to_back();
    test_reset_mid_wait();
    total++; if (sb_q.size() !== 0) begin $display("FAIL scoreboard_left got=%0d want=0", sb_q.size()); bad++; end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
